mem_tile_linebuf: RTL and testbench

//  Parametrised CGRA memory tile core: one DEPTH x DATA_W SRAM run as a handshaked FIFO or a

---
 rtl/mem_tile_pkg.sv | 19 +
 rtl/mem_tile_sram_1r1w.sv | 24 ++
 rtl/mem_tile_linebuf.sv | 141 ++++++++++++++
 tb/tb_mem_tile_linebuf.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_tile_pkg.sv
// rtl/mem_tile_pkg.sv - mode encoding, register indices and config address fields for the memory tile
package mem_tile_pkg;

  typedef enum logic [1:0] {
    MODE_OFF     = 2'd0,
    MODE_FIFO    = 2'd1,
    MODE_LINEBUF = 2'd2
  } mode_e;

  localparam logic [7:0] REG_MODE     = 8'd0;
  localparam logic [7:0] REG_LB_DEPTH = 8'd1;
  localparam logic [7:0] REG_COUNT    = 8'd2;

  localparam int CFG_TILE_LSB = 0;
  localparam int CFG_TILE_W   = 16;
  localparam int CFG_IDX_LSB  = 16;
  localparam int CFG_IDX_W    = 8;

endpackage

// File: rtl/mem_tile_sram_1r1w.sv
// rtl/mem_tile_sram_1r1w.sv - DEPTH x DATA_W SRAM, one write port, one synchronous read port
module mem_tile_sram_1r1w #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 512,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Same-address read and write in one cycle returns the old word.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/mem_tile_linebuf.sv
// rtl/mem_tile_linebuf.sv - CGRA memory tile core: FIFO or fixed-delay line buffer over one SRAM
// Optional config readback port built when MEM_TILE_CFG_READBACK_EN is defined.
module mem_tile_linebuf
  import mem_tile_pkg::*;
#(
  parameter int          DATA_W  = 16,
  parameter int          DEPTH   = 512,
  parameter int          ADDR_W  = $clog2(DEPTH),
  parameter logic [15:0] TILE_ID = 16'h18
) (
  input  logic              clk_in,
  input  logic              reset,
  input  logic              config_en,
  input  logic [31:0]       config_addr,
  input  logic [31:0]       config_data,
`ifdef MEM_TILE_CFG_READBACK_EN
  output logic [31:0]       read_data,
`endif
  input  logic              wen_in,
  input  logic [DATA_W-1:0] data_in,
  input  logic              ren_in,
  output logic [DATA_W-1:0] data_out,
  output logic              valid_out,
  output logic              full,
  output logic              empty
);

  localparam logic [ADDR_W:0]   DEPTH_C = DEPTH[ADDR_W:0];
  localparam logic [ADDR_W:0]   CNT_ONE = 1;
  localparam logic [ADDR_W-1:0] PTR_ONE = 1;

  logic [1:0]        mode_q;
  logic [ADDR_W:0]   lb_depth_q, lb_eff, lb_wdata, count_q, count_d;
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [DATA_W-1:0] data_hold, sram_rdata;
  logic [7:0]        cfg_idx;
  logic              read_valid, tile_hit, cfg_wr, flush;
  logic              is_fifo, is_lb, pop, push, lb_rd, sram_re;
  logic              unused_cfg_hi;

  assign unused_cfg_hi = ^config_addr[31:24];

  assign tile_hit = config_addr[CFG_TILE_LSB +: CFG_TILE_W] == TILE_ID;
  assign cfg_idx  = config_addr[CFG_IDX_LSB +: CFG_IDX_W];
  assign cfg_wr   = config_en && tile_hit;
  assign flush    = cfg_wr && (cfg_idx == REG_MODE || cfg_idx == REG_LB_DEPTH);

  assign is_fifo = mode_q == MODE_FIFO;
  assign is_lb   = mode_q == MODE_LINEBUF;
  assign lb_eff  = (lb_depth_q == '0) ? CNT_ONE : lb_depth_q;

  assign full  = is_lb ? (count_q == lb_eff) : (count_q == DEPTH_C);
  assign empty = count_q == '0;

  // LB_DEPTH is stored already clamped to 1..DEPTH.
  always_comb begin
    if (config_data == 32'd0)             lb_wdata = CNT_ONE;
    else if (config_data > 32'(DEPTH))    lb_wdata = DEPTH_C;
    else                                  lb_wdata = config_data[ADDR_W:0];
  end

  always_comb begin
    pop     = 1'b0;
    push    = 1'b0;
    lb_rd   = 1'b0;
    count_d = count_q;
    if (!flush) begin
      if (is_fifo) begin
        pop     = ren_in && !empty;
        push    = wen_in && (!full || pop);
        count_d = count_q + {{ADDR_W{1'b0}}, push} - {{ADDR_W{1'b0}}, pop};
      end else if (is_lb && wen_in) begin
        // Once the window is full each write also retires the oldest word.
        push  = 1'b1;
        lb_rd = full;
        if (!full) count_d = count_q + CNT_ONE;
      end
    end
  end

  assign sram_re = pop || lb_rd;

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      mode_q     <= MODE_OFF;
      lb_depth_q <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_q    <= '0;
      read_valid <= 1'b0;
      data_hold  <= '0;
    end else begin
      if (cfg_wr && cfg_idx == REG_MODE)     mode_q     <= config_data[1:0];
      if (cfg_wr && cfg_idx == REG_LB_DEPTH) lb_depth_q <= lb_wdata;
      if (flush) begin
        wr_ptr  <= '0;
        rd_ptr  <= '0;
        count_q <= '0;
      end else begin
        if (push)    wr_ptr <= wr_ptr + PTR_ONE;
        if (sram_re) rd_ptr <= rd_ptr + PTR_ONE;
        count_q <= count_d;
      end
      read_valid <= sram_re;
      if (read_valid) data_hold <= sram_rdata;
    end
  end

  // The SRAM output register has no reset, so data_out falls back to the held copy.
  assign valid_out = read_valid;
  assign data_out  = read_valid ? sram_rdata : data_hold;

`ifdef MEM_TILE_CFG_READBACK_EN
  always_comb begin
    read_data = '0;
    if (tile_hit) begin
      case (cfg_idx)
        REG_MODE:     read_data[1:0]      = mode_q;
        REG_LB_DEPTH: read_data[ADDR_W:0] = lb_depth_q;
        REG_COUNT:    read_data[ADDR_W:0] = count_q;
        default:      read_data           = '0;
      endcase
    end
  end
`endif

  mem_tile_sram_1r1w #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_sram (
    .clk   (clk_in),
    .we    (push),
    .waddr (wr_ptr),
    .wdata (data_in),
    .re    (sram_re),
    .raddr (rd_ptr),
    .rdata (sram_rdata)
  );

endmodule

// File: tb/tb_mem_tile_linebuf.sv
// tb/tb_mem_tile_linebuf.sv - randomized bench for mem_tile_linebuf against a queue-based reference
module tb_mem_tile_linebuf;

  localparam int          DATA_W  = 16;
  localparam int          DEPTH   = 16;
  localparam int          ADDR_W  = $clog2(DEPTH);
  localparam logic [15:0] TILE_ID = 16'h18;

  logic              clk_in = 1'b0;
  logic              reset = 1'b1;
  logic              config_en = 1'b0;
  logic [31:0]       config_addr = '0;
  logic [31:0]       config_data = '0;
  logic              wen_in = 1'b0;
  logic              ren_in = 1'b0;
  logic [DATA_W-1:0] data_in = '0;
  logic [DATA_W-1:0] data_out;
  logic              valid_out, full, empty;
`ifdef MEM_TILE_CFG_READBACK_EN
  logic [31:0]       read_data;
`endif

  mem_tile_linebuf #(
    .DATA_W (DATA_W), .DEPTH (DEPTH), .ADDR_W (ADDR_W), .TILE_ID (TILE_ID)
  ) dut (
    .clk_in      (clk_in),
    .reset       (reset),
    .config_en   (config_en),
    .config_addr (config_addr),
    .config_data (config_data),
`ifdef MEM_TILE_CFG_READBACK_EN
    .read_data   (read_data),
`endif
    .wen_in      (wen_in),
    .data_in     (data_in),
    .ren_in      (ren_in),
    .data_out    (data_out),
    .valid_out   (valid_out),
    .full        (full),
    .empty       (empty)
  );

  always #5 clk_in = ~clk_in;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference: the tile's contents as a plain queue, oldest first.
  int                m_mode = 0;
  int                m_lb = 1;
  logic [DATA_W-1:0] m_q[$];
  logic              e_valid = 1'b0;
  logic [DATA_W-1:0] e_data = '0;

  function automatic int eff_lb(input logic [31:0] d);
    if (d == 0) return 1;
    if (d > DEPTH) return DEPTH;
    return int'(d);
  endfunction

  function automatic logic m_full();
    return (m_mode == 2) ? (m_q.size() == m_lb) : (m_q.size() == DEPTH);
  endfunction

  function automatic logic m_empty();
    return m_q.size() == 0;
  endfunction

  task automatic model_op(input logic w, input logic [DATA_W-1:0] d, input logic r);
    bit can_pop, can_push;
    e_valid = 1'b0;
    if (m_mode == 1) begin
      can_pop  = r && m_q.size() > 0;
      can_push = w && (m_q.size() < DEPTH || can_pop);
      if (can_pop) begin e_data = m_q.pop_front(); e_valid = 1'b1; end
      if (can_push) m_q.push_back(d);
    end else if (m_mode == 2 && w) begin
      m_q.push_back(d);
      if (m_q.size() > m_lb) begin e_data = m_q.pop_front(); e_valid = 1'b1; end
    end
  endtask

  task automatic cycle(input logic w, input logic [DATA_W-1:0] d, input logic r);
    wen_in = w; data_in = d; ren_in = r;
    model_op(w, d, r);
    @(posedge clk_in); #1;
    wen_in = 1'b0; ren_in = 1'b0;
  endtask

  task automatic cfg(input logic [15:0] tile, input logic [7:0] idx, input logic [31:0] val, input logic w);
    logic [DATA_W-1:0] d;
    d = DATA_W'($urandom);
    config_en = 1'b1; config_addr = {8'hA5, idx, tile}; config_data = val;
    wen_in = w; ren_in = w; data_in = d;
    if (tile == TILE_ID && idx <= 8'd1) begin
      if (idx == 8'd0) m_mode = (val[1:0] == 2'd3) ? 0 : int'(val[1:0]);
      else             m_lb = eff_lb(val);
      m_q.delete();
      e_valid = 1'b0;
    end else begin
      model_op(w, d, w);
    end
    @(posedge clk_in); #1;
    config_en = 1'b0; wen_in = 1'b0; ren_in = 1'b0;
  endtask

  task automatic model_reset();
    m_mode = 0; m_lb = 1; m_q.delete(); e_valid = 1'b0; e_data = '0;
  endtask

  task automatic test_reset();
    #2;
    n_cmp++; if (empty !== 1'b1) begin n_bad++; $display("FAIL reset_empty got %b want 1", empty); end
    n_cmp++; if (full !== 1'b0) begin n_bad++; $display("FAIL reset_full got %b want 0", full); end
    n_cmp++; if (valid_out !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %b want 0", valid_out); end
    n_cmp++; if (data_out !== '0) begin n_bad++; $display("FAIL reset_data got %h want 0", data_out); end
    @(negedge clk_in); reset = 1'b0;
    @(posedge clk_in); #1;
    model_reset();
  endtask

  task automatic test_fifo_basic();
    logic [DATA_W-1:0] want;
    cfg(TILE_ID, 8'd0, 32'd1, 1'b0);
    for (int i = 1; i <= 3; i++) cycle(1'b1, DATA_W'(i), 1'b0);
    for (int i = 1; i <= 3; i++) begin
      cycle(1'b0, '0, 1'b1);
      want = DATA_W'(i);
      n_cmp++;
      if (valid_out !== 1'b1 || data_out !== want) begin
        n_bad++; $display("FAIL fifo_basic pop%0d got v=%b d=%h want v=1 d=%h", i, valid_out, data_out, want);
      end
    end
    cycle(1'b0, '0, 1'b0);
    n_cmp++;
    if (empty !== 1'b1 || valid_out !== 1'b0) begin
      n_bad++; $display("FAIL fifo_basic_after got e=%b v=%b want e=1 v=0", empty, valid_out);
    end
  endtask

  task automatic test_fifo_full();
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, DATA_W'($urandom), 1'b0);
    n_cmp++; if (full !== 1'b1) begin n_bad++; $display("FAIL fifo_full got %b want 1", full); end
    cycle(1'b1, 16'hBEEF, 1'b1);
    n_cmp++;
    if (valid_out !== 1'b1 || data_out !== e_data || full !== 1'b1) begin
      n_bad++; $display("FAIL fifo_full_pushpop got v=%b d=%h f=%b want v=1 d=%h f=1", valid_out, data_out, full, e_data);
    end
    cycle(1'b1, 16'hDEAD, 1'b0);
    for (int i = 0; i < DEPTH + 2; i++) begin
      cycle(1'b0, '0, 1'b1);
      n_cmp++;
      if (valid_out !== e_valid || (e_valid && data_out !== e_data) || empty !== m_empty()) begin
        n_bad++; $display("FAIL fifo_drain c%0d got v=%b d=%h e=%b want v=%b d=%h e=%b",
                          i, valid_out, data_out, empty, e_valid, e_data, m_empty());
      end
    end
  endtask

  task automatic test_fifo_random();
    int pw, pr;
    for (int i = 0; i < 300; i++) begin
      pw = (i < 150) ? 80 : 30;
      pr = (i < 150) ? 30 : 80;
      cycle(($urandom_range(99) < pw), DATA_W'($urandom), ($urandom_range(99) < pr));
      n_cmp++;
      if (valid_out !== e_valid || (e_valid && data_out !== e_data) || full !== m_full() || empty !== m_empty()) begin
        n_bad++; $display("FAIL fifo_rand c%0d got v=%b d=%h f=%b e=%b want v=%b d=%h f=%b e=%b",
                          i, valid_out, data_out, full, empty, e_valid, e_data, m_full(), m_empty());
      end
    end
  endtask

  task automatic test_linebuf();
    logic [DATA_W-1:0] want;
    cfg(TILE_ID, 8'd0, 32'd2, 1'b0);
    cfg(TILE_ID, 8'd1, 32'd4, 1'b0);
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, DATA_W'(10 + i), 1'b0);
      want = DATA_W'(10 + i - 4);
      n_cmp++;
      if (valid_out !== (i >= 4) || (i >= 4 && data_out !== want)) begin
        n_bad++; $display("FAIL lb4 w%0d got v=%b d=%h want v=%b d=%h", i, valid_out, data_out, (i >= 4), want);
      end
    end
    cycle(1'b0, '0, 1'b1);
    n_cmp++;
    if (valid_out !== 1'b0 || full !== 1'b1) begin
      n_bad++; $display("FAIL lb4_idle got v=%b f=%b want v=0 f=1", valid_out, full);
    end
  endtask

  task automatic test_linebuf_random();
    logic [31:0] depths [4];
    depths[0] = 32'd0; depths[1] = 32'd16; depths[2] = 32'd100; depths[3] = 32'd3;
    for (int k = 0; k < 4; k++) begin
      cfg(TILE_ID, 8'd1, depths[k], 1'b1);
      for (int i = 0; i < 60; i++) begin
        cycle(($urandom_range(99) < 70), DATA_W'($urandom), $urandom_range(1));
        n_cmp++;
        if (valid_out !== e_valid || (e_valid && data_out !== e_data) || full !== m_full() || empty !== m_empty()) begin
          n_bad++; $display("FAIL lb_rand L%0d c%0d got v=%b d=%h f=%b e=%b want v=%b d=%h f=%b e=%b",
                            depths[k], i, valid_out, data_out, full, empty, e_valid, e_data, m_full(), m_empty());
        end
      end
    end
  endtask

  task automatic test_config();
    cfg(TILE_ID, 8'd1, 32'd4, 1'b0);
    for (int i = 0; i < 6; i++) cycle(1'b1, DATA_W'(16'h100 + i), 1'b0);
    cfg(16'h19, 8'd1, 32'd1, 1'b1);
    cfg(16'h19, 8'd0, 32'd0, 1'b1);
    for (int i = 0; i < 6; i++) begin
      cycle(1'b1, DATA_W'($urandom), 1'b0);
      n_cmp++;
      if (valid_out !== e_valid || (e_valid && data_out !== e_data)) begin
        n_bad++; $display("FAIL cfg_other_tile c%0d got v=%b d=%h want v=%b d=%h", i, valid_out, data_out, e_valid, e_data);
      end
    end
    cfg(TILE_ID, 8'd0, 32'd1, 1'b0);
    for (int i = 0; i < 5; i++) cycle(1'b1, DATA_W'($urandom), 1'b0);
    cfg(TILE_ID, 8'd0, 32'd1, 1'b1);
    n_cmp++;
    if (empty !== 1'b1 || valid_out !== 1'b0) begin
      n_bad++; $display("FAIL cfg_flush got e=%b v=%b want e=1 v=0", empty, valid_out);
    end
    cfg(TILE_ID, 8'd0, 32'd3, 1'b0);
    cycle(1'b1, 16'h1234, 1'b1);
    n_cmp++;
    if (empty !== 1'b1 || valid_out !== 1'b0) begin
      n_bad++; $display("FAIL cfg_mode3_off got e=%b v=%b want e=1 v=0", empty, valid_out);
    end
  endtask

  task automatic test_reset_mid();
    cfg(TILE_ID, 8'd0, 32'd1, 1'b0);
    for (int i = 0; i < 5; i++) cycle(1'b1, DATA_W'(16'h50 + i), 1'b0);
    cycle(1'b0, '0, 1'b1);
    reset = 1'b1;
    #2;
    n_cmp++;
    if (empty !== 1'b1 || full !== 1'b0 || valid_out !== 1'b0 || data_out !== '0) begin
      n_bad++; $display("FAIL reset_mid got e=%b f=%b v=%b d=%h want e=1 f=0 v=0 d=0", empty, full, valid_out, data_out);
    end
    @(negedge clk_in); reset = 1'b0;
    @(posedge clk_in); #1;
    model_reset();
    cycle(1'b1, 16'h7777, 1'b1);
    cycle(1'b0, '0, 1'b1);
    n_cmp++;
    if (empty !== 1'b1 || valid_out !== 1'b0) begin
      n_bad++; $display("FAIL reset_mid_mode_off got e=%b v=%b want e=1 v=0", empty, valid_out);
    end
  endtask

`ifdef MEM_TILE_CFG_READBACK_EN
  task automatic test_readback();
    cfg(TILE_ID, 8'd1, 32'd7, 1'b0);
    config_addr = {8'h00, 8'd1, TILE_ID}; #1;
    n_cmp++; if (read_data !== 32'd7) begin n_bad++; $display("FAIL rb_lb got %h want 7", read_data); end
    cfg(TILE_ID, 8'd0, 32'd1, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b1, DATA_W'(i), 1'b0);
    config_addr = {8'h00, 8'd2, TILE_ID}; #1;
    n_cmp++; if (read_data !== 32'(m_q.size())) begin n_bad++; $display("FAIL rb_count got %h want %h", read_data, m_q.size()); end
    config_addr = {8'h00, 8'd2, 16'h19}; #1;
    n_cmp++; if (read_data !== 32'd0) begin n_bad++; $display("FAIL rb_other got %h want 0", read_data); end
    @(posedge clk_in); #1;
  endtask
`endif

  initial begin
    test_reset();
    test_fifo_basic();
    test_fifo_full();
    test_fifo_random();
    test_linebuf();
    test_linebuf_random();
    test_config();
    test_reset_mid();
`ifdef MEM_TILE_CFG_READBACK_EN
    test_readback();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
